// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM port-0 arbiter: default geometry,
// requester ids and the arbiter state encoding.
package sram_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_WMASKS = DATA_WIDTH / 8;
    localparam int NUM_REQ    = 2;

    localparam int REQ_HOST = 0;
    localparam int REQ_FPU  = 1;

    typedef enum logic {
        LK_UNLOCKED = 1'b0,
        LK_LOCKED   = 1'b1
    } lock_state_e;

    // Architectural arbiter state, grouped so a checker can bind to one signal.
    typedef struct packed {
        lock_state_e state;
        logic        owner;
        logic        ptr;
    } arb_state_t;

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a bounded lock for read-modify-write
// sequences. Grants are combinational; pointer/lock state updates on a grant.
//
// Handshake: a request on requester i completes in the cycle where
// valid_i[i] & grant_o[i]; the grant never waits on anything but valid_i and
// the arbiter state, so there is no back-pressure.
module rr_arb2
    import sram_pkg::*;
#(
    parameter int LOCK_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [NUM_REQ-1:0] lock_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

    arb_state_t       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             win;
    logic             any;
    logic [CNT_W-1:0] run_cnt;

    // State register: pointer, lock owner and consecutive-grant counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= '{state: LK_UNLOCKED, owner: 1'b0, ptr: 1'(REQ_HOST)};
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // Pick the winner (lock owner first, then pointer order) and compute next state.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        grant_o = '0;
        win     = 1'b0;
        any     = 1'b0;
        run_cnt = '0;

        if (st_q.state == LK_LOCKED && valid_i[st_q.owner]) begin
            any = 1'b1;
            win = st_q.owner;
        end else if (valid_i[st_q.ptr]) begin
            any = 1'b1;
            win = st_q.ptr;
        end else if (valid_i[~st_q.ptr]) begin
            any = 1'b1;
            win = ~st_q.ptr;
        end

        // Nothing is granted while reset is held.
        if (!rst_n) begin
            any = 1'b0;
        end

        if (any) begin
            grant_o[win] = 1'b1;
            if (st_q.state == LK_LOCKED && win != st_q.owner) begin
                // Owner idle: the other side borrows the port, lock is kept.
                st_d.ptr = ~win;
            end else begin
                run_cnt = (st_q.state == LK_LOCKED) ? cnt_q + CNT_W'(1) : CNT_W'(1);
                if (lock_i[win] && run_cnt < LOCK_MAX_C) begin
                    st_d.state = LK_LOCKED;
                    st_d.owner = win;
                    cnt_d      = run_cnt;
                end else begin
                    // Voluntary or forced release hands priority to the other side.
                    st_d.state = LK_UNLOCKED;
                    st_d.owner = 1'b0;
                    st_d.ptr   = ~win;
                    cnt_d      = '0;
                end
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares SRAM RW port 0 between the host loader (req0) and the FPU engine
// (req1). Port pins are driven straight from the granted request; read data
// comes back one cycle later, tagged one-hot to the requester that issued it.
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = sram_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sram_pkg::DATA_WIDTH,
    parameter int NUM_WMASKS = sram_pkg::NUM_WMASKS,
    parameter int LOCK_MAX   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              rq_valid,
    input  logic [1:0]              rq_we,
    input  logic [1:0]              rq_lock,
    input  logic [2*NUM_WMASKS-1:0] rq_wmask,
    input  logic [2*ADDR_WIDTH-1:0] rq_addr,
    input  logic [2*DATA_WIDTH-1:0] rq_wdata,
    output logic [1:0]              rq_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    sram_csb0,
    output logic                    sram_web0,
    output logic [NUM_WMASKS-1:0]   sram_wmask0,
    output logic [ADDR_WIDTH-1:0]   sram_addr0,
    output logic [DATA_WIDTH-1:0]   sram_din0,
    input  logic [DATA_WIDTH-1:0]   sram_dout0
);

    logic [1:0] grant;
    logic       gidx;
    logic       gnt_any;
    logic [1:0] rsp_pend_q, rsp_pend_d;

    rr_arb2 #(
        .LOCK_MAX(LOCK_MAX)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid_i(rq_valid),
        .lock_i (rq_lock),
        .grant_o(grant)
    );

    assign rq_ready = grant;
    assign gidx     = grant[sram_pkg::REQ_FPU];
    assign gnt_any  = |grant;

    // Steer the granted request onto the SRAM pins; idle pins are parked inactive.
    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (gnt_any) begin
            sram_csb0  = 1'b0;
            sram_web0  = ~rq_we[gidx];
            sram_addr0 = gidx ? rq_addr[ADDR_WIDTH +: ADDR_WIDTH]
                              : rq_addr[0 +: ADDR_WIDTH];
            sram_din0  = gidx ? rq_wdata[DATA_WIDTH +: DATA_WIDTH]
                              : rq_wdata[0 +: DATA_WIDTH];
            if (rq_we[gidx]) begin
                sram_wmask0 = gidx ? rq_wmask[NUM_WMASKS +: NUM_WMASKS]
                                   : rq_wmask[0 +: NUM_WMASKS];
            end
        end
    end

    // A read grant this cycle becomes a tagged response next cycle.
    always_comb begin
        rsp_pend_d = grant & ~rq_we;
    end

    // Response pipe; reset drops any pending response immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pend_q <= '0;
        end else begin
            rsp_pend_q <= rsp_pend_d;
        end
    end

    assign rsp_valid = rsp_pend_q;
    assign rsp_rdata = sram_dout0;

endmodule
